// File: rtl/adder_share_ctrl.sv
// Round-robin scheduler sharing one four-lane registered adder among N requesters.
// One request at a time: accept, issue to adder, capture registered sum, respond.
module adder_share_ctrl #(
  parameter int unsigned W   = 8,
  parameter int unsigned N   = 4,
  localparam int unsigned IDW = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N*4*W-1:0]     req_ins,
  input  logic [N-1:0]         req_cin,
  output logic [4*W-1:0]       adder_ins,
  output logic                 adder_cin,
  input  logic [W+1:0]         adder_sm_r,
  input  logic                 adder_sm_zero_r,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [W+1:0]         rsp_sum,
  output logic                 rsp_zero,
  output logic                 busy
);

  localparam int unsigned OPW = 4 * W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   cand;
  logic             grant_found;
  logic             accept_c;

  logic [OPW-1:0]   op_r;
  logic             cin_r;
  logic [IDW-1:0]   id_r;

  logic [OPW-1:0]   req_op [N];

  for (genvar i = 0; i < int'(N); i++) begin : g_slice
    assign req_op[i] = req_ins[i*OPW +: OPW];
  end

  // Round-robin search starting just after the last granted requester
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= int'(N); k++) begin
      cand = IDW'((int'(last_grant) + k) % int'(N));
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign accept_c  = (state_q == IDLE) && grant_found;
  assign req_ready = (rst_n && accept_c) ? (N'(1) << grant_idx) : '0;

  assign adder_ins = op_r;
  assign adder_cin = cin_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_found) state_d = ISSUE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, grant pointer and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r       <= '0;
      cin_r      <= 1'b0;
      id_r       <= '0;
      last_grant <= IDW'(N - 1);
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_sum    <= '0;
      rsp_zero   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      if (accept_c) begin
        op_r       <= req_op[grant_idx];
        cin_r      <= req_cin[grant_idx];
        id_r       <= grant_idx;
        last_grant <= grant_idx;
      end
      if (state_q == CAPTURE) begin
        rsp_sum   <= adder_sm_r;
        rsp_zero  <= adder_sm_zero_r;
        rsp_id    <= id_r;
        rsp_valid <= 1'b1;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Scoreboard bench for adder_share_ctrl with a behavioural registered four-lane adder.
module tb_adder_share_ctrl;

  localparam int unsigned W   = 8;
  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*4*W-1:0]  req_ins;
  logic [N-1:0]      req_cin;
  logic [4*W-1:0]    adder_ins;
  logic              adder_cin;
  logic [W+1:0]      adder_sm_r;
  logic              adder_sm_zero_r;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W+1:0]      rsp_sum;
  logic              rsp_zero;
  logic              busy;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W+1:0]   sum;
    logic           zero;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   checks    = 0;
  int   failures  = 0;
  int   cyc_cnt   = 0;
  int   grant_cyc = 0;
  int   prev_cyc  = 0;

  adder_share_ctrl #(.W(W), .N(N)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_ins        (req_ins),
    .req_cin        (req_cin),
    .adder_ins      (adder_ins),
    .adder_cin      (adder_cin),
    .adder_sm_r     (adder_sm_r),
    .adder_sm_zero_r(adder_sm_zero_r),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_id         (rsp_id),
    .rsp_sum        (rsp_sum),
    .rsp_zero       (rsp_zero),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Behavioural shared adder: one register stage on sum and zero flag
  logic [W+1:0] adder_sum_c;
  assign adder_sum_c = (W+2)'(adder_ins[7:0]) + (W+2)'(adder_ins[15:8]) +
                       (W+2)'(adder_ins[23:16]) + (W+2)'(adder_ins[31:24]) +
                       (W+2)'(adder_cin);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adder_sm_r      <= '0;
      adder_sm_zero_r <= 1'b0;
    end else begin
      adder_sm_r      <= adder_sum_c;
      adder_sm_zero_r <= (adder_sum_c == '0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic set_ops(input int r, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] z, input logic [7:0] w);
    req_ins[r*32 +: 32] = {w, z, y, x};
  endtask

  task automatic push(input int id, input int sum, input logic zero);
    rsp_t e;
    e.id   = IDW'(id);
    e.sum  = (W+2)'(sum);
    e.zero = zero;
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for a grant at a falling edge and check which requester got it
  task automatic wait_grant(input logic [N-1:0] exp, input string nm);
    int n = 0;
    @(negedge clk);
    while (req_ready === '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(req_ready), 32'(exp));
    grant_cyc = cyc_cnt;
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: pops the scoreboard on every completed handshake
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual id=%0d sum=%0d expected none", rsp_id, rsp_sum);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_id",   32'(rsp_id),   32'(mon_e.id));
        chk("rsp_sum",  32'(rsp_sum),  32'(mon_e.sum));
        chk("rsp_zero", 32'(rsp_zero), 32'(mon_e.zero));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_ins = '0; req_cin = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_adder_ins", adder_ins, 0);
    chk("rst_adder_cin", 32'(adder_cin), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id",    32'(rsp_id), 0);
    chk("rst_rsp_sum",   32'(rsp_sum), 0);
    chk("rst_rsp_zero",  32'(rsp_zero), 0);
    chk("rst_busy",      32'(busy), 0);
    drive_edge();
    rst_n = 1'b1;

    // T1: requester 0, lanes 1,2,3,4, cin=1 -> 11
    set_ops(0, 8'd1, 8'd2, 8'd3, 8'd4);
    req_cin = 4'b0001; rsp_ready = 1'b1; req_valid = 4'b0001;
    push(0, 11, 1'b0);
    wait_grant(4'b0001, "t1_grant");
    drive_edge();
    req_valid = '0;
    @(negedge clk);
    chk("t1_issue_adder_ins", adder_ins, 32'h04030201);
    chk("t1_issue_adder_cin", 32'(adder_cin), 1);
    chk("t1_issue_busy",      32'(busy), 1);
    chk("t1_issue_rsp_valid", 32'(rsp_valid), 0);
    chk("t1_issue_req_ready", 32'(req_ready), 0);
    @(negedge clk);
    chk("t1_capture_rsp_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("t1_resp_rsp_valid", 32'(rsp_valid), 1);
    @(negedge clk);
    chk("t1_idle_busy",      32'(busy), 0);
    chk("t1_idle_rsp_valid", 32'(rsp_valid), 0);
    chk("t1_idle_adder_hold", adder_ins, 32'h04030201);

    // T2: requester 2, all zero -> sum 0, zero flag
    drive_edge();
    set_ops(2, 8'd0, 8'd0, 8'd0, 8'd0);
    req_cin = 4'b0000; req_valid = 4'b0100;
    push(2, 0, 1'b1);
    wait_grant(4'b0100, "t2_grant");
    drive_edge();
    req_valid = '0;

    // T3: requester 3, all 255 with cin -> 1021
    set_ops(3, 8'd255, 8'd255, 8'd255, 8'd255);
    req_cin = 4'b1000; req_valid = 4'b1000;
    push(3, 1021, 1'b0);
    wait_grant(4'b1000, "t3_grant");
    drive_edge();
    req_valid = '0;

    // T4: all requesters valid, fair rotation 0,1,2,3,0,1,2,3
    for (int i = 0; i < 4; i++)
      set_ops(i, 8'((i+1)*16), 8'((i+1)*16), 8'((i+1)*16), 8'((i+1)*16));
    req_cin = 4'b1010; req_valid = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      int id;
      id = t % 4;
      push(id, 64*(id+1) + (id & 1), 1'b0);
      wait_grant(4'(1 << id), "t4_grant");
      chk("t4_grant_busy", 32'(busy), 0);
      if (t > 0) chk("t4_spacing", 32'(grant_cyc - prev_cyc), 4);
      prev_cyc = grant_cyc;
      drive_edge();
      if (t == 7) req_valid = '0;
      @(negedge clk);
      chk("t4_issue_busy", 32'(busy), 1);
    end
    repeat (3) drive_edge();

    // T5: response stall with requesters 1 and 2 waiting
    rsp_ready = 1'b0; req_valid = 4'b0110;
    push(1, 129, 1'b0);
    wait_grant(4'b0010, "t5_grant1");
    drive_edge();
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t5_stall_rsp_valid", 32'(rsp_valid), 1);
      chk("t5_stall_rsp_id",    32'(rsp_id), 1);
      chk("t5_stall_rsp_sum",   32'(rsp_sum), 129);
      chk("t5_stall_req_ready", 32'(req_ready), 0);
    end
    drive_edge();
    rsp_ready = 1'b1;
    push(2, 192, 1'b0);
    wait_grant(4'b0100, "t5_grant2");
    drive_edge();
    req_valid = '0;

    // T6: reset during CAPTURE, then pointer restarts at requester 0
    set_ops(0, 8'd1, 8'd2, 8'd3, 8'd4);
    set_ops(3, 8'd255, 8'd255, 8'd255, 8'd255);
    req_cin = 4'b1001; req_valid = 4'b0001;
    wait_grant(4'b0001, "t6_grant_abort");
    drive_edge();
    req_valid = '0;
    drive_edge();
    rst_n = 1'b0;
    #2;
    chk("t6_rst_req_ready", 32'(req_ready), 0);
    chk("t6_rst_adder_ins", adder_ins, 0);
    chk("t6_rst_adder_cin", 32'(adder_cin), 0);
    chk("t6_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("t6_rst_rsp_id",    32'(rsp_id), 0);
    chk("t6_rst_rsp_sum",   32'(rsp_sum), 0);
    chk("t6_rst_rsp_zero",  32'(rsp_zero), 0);
    chk("t6_rst_busy",      32'(busy), 0);
    req_valid = 4'b1000;
    @(negedge clk);
    chk("t6_inrst_req_ready", 32'(req_ready), 0);
    drive_edge();
    req_valid = 4'b1001;
    drive_edge();
    rst_n = 1'b1;
    push(0, 11, 1'b0);
    push(3, 1021, 1'b0);
    wait_grant(4'b0001, "t6_grant_first");
    drive_edge();
    req_valid = 4'b1000;
    wait_grant(4'b1000, "t6_grant_second");
    drive_edge();
    req_valid = '0;

    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
    chk("drain_queue", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_share_ctrl.md
Name: adder_share_ctrl

Overview:
- Round-robin scheduler that shares one instance of the team's four-lane registered adder among N requesters.
- Accepts one request at a time, latches its four W-bit operands and carry-in, and drives them onto the adder.
- Waits out the adder's one-cycle register latency, captures the registered sum and zero flag, and returns them with the requester index over a valid/ready response channel.
- Sits between requesting engines and the adder; it is the only driver of the adder inputs.

Parameters:
W, 8, lane width; adder sum width is W+2.
N, 4, number of requesters (2..16).
IDW, derived localparam = max(1, clog2(N)), width of requester index.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  N  per-requester request valid
req_ready  output  N  per-requester accept strobe, one-hot or zero
req_ins  input  N*4*W  packed operands; requester i occupies bits [(i+1)*4*W-1 : i*4*W]; lane order x,y,z,w from LSB
req_cin  input  N  per-requester carry-in
adder_ins  output  4*W  operands to adder, driven from latched register
adder_cin  output  1  carry-in to adder, driven from latched register
adder_sm_r  input  W+2  registered sum from adder
adder_sm_zero_r  input  1  registered zero flag from adder
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  IDW  index of the served requester
rsp_sum  output  W+2  captured sum
rsp_zero  output  1  captured zero flag
busy  output  1  high in every state except IDLE

Behaviour:
Reset values:
- req_ready=0, adder_ins=0, adder_cin=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_zero=0, busy=0.
- State = IDLE; round-robin pointer last_grant = N-1, so requester 0 has first priority.

State machine: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.

IDLE:
- If any req_valid bit is set, select the first set bit searching last_grant+1, last_grant+2, ... with wrap modulo N.
- req_ready[g] is combinational: high in IDLE only for the selected g. This is the accept cycle.
- At the clock edge, latch req_ins slice g into op_r and req_cin[g] into cin_r, store g in id_r, set last_grant=g, and go to ISSUE.
- If no req_valid bit is set, stay in IDLE with req_ready=0.

ISSUE:
- adder_ins=op_r and adder_cin=cin_r are stable; the adder registers sm_r at the closing edge.
- Go to CAPTURE unconditionally.

CAPTURE:
- adder_sm_r and adder_sm_zero_r are now valid for op_r.
- At the edge, load rsp_sum, rsp_zero and rsp_id=id_r, set rsp_valid=1, and go to RESP.

RESP:
- Hold rsp_valid and rsp_* stable until rsp_ready=1.
- On the edge with rsp_valid && rsp_ready, clear rsp_valid and go to IDLE.
- req_ready stays 0 in RESP (no overlap).

Timing and operand handling:
- Latency from the accept edge to rsp_valid=1 is 2 clock edges (rsp_valid is visible in the second cycle after the accept cycle).
- Minimum request spacing is 4 cycles with rsp_ready held at 1.
- adder_ins and adder_cin hold op_r and cin_r in all states, including IDLE after a transaction (no return to 0).
- Arithmetic is performed by the adder only. rsp_sum carries the full W+2 bits, with no truncation; the maximum is 4*(2^W-1)+1.

Arbitration and boundary conditions:
- A requester that drops req_valid before it is granted is simply skipped.
- Requests are not queued; req_valid must be held until req_ready is seen.
- Fairness: with all N requesters continuously valid, grants cycle 0,1,...,N-1,0,...
- When only one requester is active, it is granted back-to-back.
- rsp_ready high in the same cycle rsp_valid rises takes effect on the following edge; no combinational path from rsp_ready to req_ready.
- Reset asserted mid-transaction aborts immediately. All outputs return to reset values, the pending response is discarded, and the pointer returns to N-1.

Test Plan:
1. After reset, N=4, W=8: req_valid=0001, lanes x=1,y=2,z=3,w=4, cin=1, rsp_ready=1 -> req_ready=0001 for one cycle; rsp_valid rises 2 edges after accept with rsp_sum=11, rsp_zero=0, rsp_id=0.
2. All lanes 0, cin=0 from requester 2 -> rsp_sum=0, rsp_zero=1, rsp_id=2.
3. All lanes 255, cin=1 from requester 3 -> rsp_sum=1021 (10-bit, no overflow), rsp_zero=0, rsp_id=3.
4. req_valid=1111 held for 8 transactions, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1,2,3; each grant 4 cycles apart; busy low exactly one cycle between transactions.
5. rsp_ready held 0 for 5 cycles in RESP while req_valid=0110 -> rsp_valid and rsp_* stable, req_ready=0000 throughout; after rsp_ready=1 the next grant goes to the next requester after the previous grant in round-robin order.
6. Assert rst_n=0 during CAPTURE -> all outputs return to 0 asynchronously, busy=0. After release with req_valid=1000 then 1001, requester 0 is granted first when both are valid.
